// File: rtl/openhw_bit_select_pkg.sv
// Shared types and helpers for the BMU select path (state encoding, word-op width).
package openhw_bmu_pkg;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_SCAN,
        SEL_FINE,
        SEL_DONE
    } selstate_t;

    // Number of low bits scanned by a word (W64) operation.
    localparam int SEL_WORD_BITS = 32;

    // clog2 that never returns 0, so index fields stay at least one bit wide.
    function automatic int selIdxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/openhw_bit_select_if.sv
// Request/response bundle of the bit-select unit: start/flush request with operands,
// ready/busy/done status and the held result.
interface openhw_bit_select_if #(
    parameter int WIDTH = 64
);
    logic                     Start;
    logic                     Flush;
    logic [WIDTH-1:0]         A;
    logic [$clog2(WIDTH)-1:0] K;
    logic                     W64;
    logic                     Ready;
    logic                     Busy;
    logic                     Done;
    logic                     Found;
    logic [WIDTH-1:0]         SelResult;

    modport master (
        output Start, Flush, A, K, W64,
        input  Ready, Busy, Done, Found, SelResult
    );

    modport slave (
        input  Start, Flush, A, K, W64,
        output Ready, Busy, Done, Found, SelResult
    );
endinterface

// File: rtl/openhw_bit_select_chunk_select.sv
// Combinational in-chunk select: position of the i_rank-th set bit of i_chunk,
// found by walking a running prefix popcount from the LSB.
module openhw_chunk_select #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]         i_chunk,
    input  logic [$clog2(CHUNK)-1:0] i_rank,
    output logic [$clog2(CHUNK)-1:0] o_pos
);

    localparam int IDX_W = $clog2(CHUNK);
    localparam int CNT_W = IDX_W + 1;

    // A set bit whose count of lower set bits equals the rank is the one we want.
    always_comb begin
        logic [CNT_W-1:0] prefix;
        o_pos  = '0;
        prefix = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i_chunk[i] && (prefix == {1'b0, i_rank})) begin
                o_pos = IDX_W'(i);
            end
            prefix = prefix + CNT_W'(i_chunk[i]);
        end
    end

endmodule

// File: rtl/openhw_mux2.sv
// Plain two-way multiplexer: i_sel=0 selects i_a, i_sel=1 selects i_b.
module openhw_mux2 #(
    parameter int W = 1
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/openhw_popcnt.sv
// Combinational population count of an N-bit vector.
module openhw_popcnt #(
    parameter int N = 8
) (
    input  logic [N-1:0]       i_data,
    output logic [$clog2(N):0] o_count
);

    // Sum the set bits of the input one at a time.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + ($clog2(N)+1)'(i_data[i]);
        end
    end

endmodule

// File: rtl/openhw_bit_select.sv
// Iterative select unit: index of the K-th set bit of A, scanning one CHUNK-bit
// slice per cycle from the LSB, then locating the bit inside the hit chunk.
module openhw_bit_select
    import openhw_bmu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    openhw_bit_select_if.slave       bus
);

    localparam int K_W    = $clog2(WIDTH);
    localparam int ACC_W  = K_W + 1;
    localparam int IDX_W  = $clog2(CHUNK);
    localparam int P_W    = IDX_W + 1;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CIDX_W = selIdxW(NCHUNK);

    selstate_t          r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_found;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_a;
    logic [K_W-1:0]     r_k;
    logic               r_w64;
    logic [CIDX_W-1:0]  r_c;
    logic [ACC_W-1:0]   r_acc;
    logic [CHUNK-1:0]   r_chunk;
    logic [IDX_W-1:0]   r_rank;

    logic [CHUNK-1:0]   w_chunk;
    logic [P_W-1:0]     w_p;
    logic [ACC_W-1:0]   w_sum;
    logic               w_hit;
    logic [CIDX_W-1:0]  w_lastIdx;
    logic [WIDTH-1:0]   w_missResult;
    logic [IDX_W-1:0]   w_pos;

    // Current slice: chunk index times CHUNK is just the index with IDX_W zeros appended.
    assign w_chunk = CHUNK'(r_a >> {r_c, IDX_W'(0)});

    openhw_popcnt #(.N(CHUNK)) u_popcnt (
        .i_data  (w_chunk),
        .o_count (w_p)
    );

    assign w_sum = r_acc + ACC_W'(w_p);
    assign w_hit = (w_sum > {1'b0, r_k});

    // Word ops stop after the low 32 bits; the index of the last chunk follows W64.
    openhw_mux2 #(.W(CIDX_W)) u_lastMux (
        .i_sel (r_w64),
        .i_a   (CIDX_W'(NCHUNK - 1)),
        .i_b   (CIDX_W'(SEL_WORD_BITS / CHUNK - 1)),
        .o_y   (w_lastIdx)
    );

    // A miss reports the scanned width, like the clz all-zero result.
    openhw_mux2 #(.W(WIDTH)) u_boundMux (
        .i_sel (r_w64),
        .i_a   (WIDTH'(WIDTH)),
        .i_b   (WIDTH'(SEL_WORD_BITS)),
        .o_y   (w_missResult)
    );

    openhw_chunk_select #(.CHUNK(CHUNK)) u_chunkSelect (
        .i_chunk (r_chunk),
        .i_rank  (r_rank),
        .o_pos   (w_pos)
    );

    // Control FSM with the operand, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= SEL_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_result <= '0;
            r_a      <= '0;
            r_k      <= '0;
            r_w64    <= 1'b0;
            r_c      <= '0;
            r_acc    <= '0;
            r_chunk  <= '0;
            r_rank   <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.Flush) begin
                r_state <= SEL_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    SEL_IDLE: begin
                        if (bus.Start) begin
                            r_a     <= bus.A;
                            r_k     <= bus.K;
                            r_w64   <= bus.W64;
                            r_c     <= '0;
                            r_acc   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= SEL_SCAN;
                        end
                    end
                    SEL_SCAN: begin
                        if (w_hit) begin
                            r_chunk <= w_chunk;
                            r_rank  <= IDX_W'({1'b0, r_k} - r_acc);
                            r_state <= SEL_FINE;
                        end else begin
                            r_acc <= w_sum;
                            r_c   <= r_c + CIDX_W'(1);
                            if (r_c == w_lastIdx) begin
                                r_found  <= 1'b0;
                                r_result <= w_missResult;
                                r_done   <= 1'b1;
                                r_state  <= SEL_DONE;
                            end
                        end
                    end
                    SEL_FINE: begin
                        r_result <= WIDTH'({r_c, w_pos});
                        r_found  <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= SEL_DONE;
                    end
                    SEL_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= SEL_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= SEL_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Ready     = !r_busy;
    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Found     = r_found;
    assign bus.SelResult = r_result;

endmodule

// File: tb/tb_openhw_bit_select.sv
// Directed bench for openhw_bit_select (WIDTH=64, CHUNK=8): latency, result,
// miss handling, flush, busy-start and mid-operation reset.
module tb_openhw_bit_select;

    localparam int WIDTH = 64;
    localparam int CHUNK = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    logic doneSeen;

    openhw_bit_select_if #(.WIDTH(WIDTH)) bus ();

    openhw_bit_select #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Counts negedges from startCyc until Done is seen; returns -1 on timeout.
    task automatic waitDone(input int startCyc, output int latOut);
        int cyc;
        cyc    = startCyc;
        latOut = -1;
        while (cyc < 40 && latOut < 0) begin
            @(negedge clk);
            cyc++;
            if (bus.Done === 1'b1) latOut = cyc;
        end
    endtask

    // Presents one request in the current cycle and waits for its Done.
    task automatic applyStimulus(input string tag, input logic [63:0] a, input logic [5:0] k,
                                 input logic w64, output int latOut);
        bus.A     = a;
        bus.K     = k;
        bus.W64   = w64;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".busy"}, 64'(bus.Busy), 64'd1);
        waitDone(1, latOut);
    endtask

    task automatic runCase(input string tag, input logic [63:0] a, input logic [5:0] k, input logic w64,
                           input int expLat, input logic expFound, input logic [63:0] expRes);
        int l;
        applyStimulus(tag, a, k, w64, l);
        checkOutput({tag, ".latency"}, 64'(l), 64'(expLat));
        checkOutput({tag, ".found"}, 64'(bus.Found), 64'(expFound));
        checkOutput({tag, ".result"}, bus.SelResult, expRes);
        @(negedge clk);
        checkOutput({tag, ".donePulse"}, 64'(bus.Done), 64'd0);
        checkOutput({tag, ".readyAfter"}, 64'(bus.Ready), 64'd1);
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Flush = 1'b0;
        bus.A     = '0;
        bus.K     = '0;
        bus.W64   = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset.ready", 64'(bus.Ready), 64'd1);
        checkOutput("reset.busy", 64'(bus.Busy), 64'd0);
        checkOutput("reset.done", 64'(bus.Done), 64'd0);
        checkOutput("reset.found", 64'(bus.Found), 64'd0);
        checkOutput("reset.result", bus.SelResult, 64'd0);
        reset_n = 1'b1;

        runCase("lsb", 64'h1, 6'd0, 1'b0, 3, 1'b1, 64'd0);
        runCase("msb", 64'h8000_0000_0000_0000, 6'd0, 1'b0, 10, 1'b1, 64'd63);
        runCase("split", 64'hFF00_0000_0000_00F0, 6'd5, 1'b0, 10, 1'b1, 64'd57);
        runCase("wordMiss", 64'h0000_0001_0000_0000, 6'd0, 1'b1, 5, 1'b0, 64'd32);
        runCase("dwordHit", 64'h0000_0001_0000_0000, 6'd0, 1'b0, 7, 1'b1, 64'd32);
        runCase("zero", 64'h0, 6'd0, 1'b0, 9, 1'b0, 64'd64);
        runCase("rankMiss", 64'hF, 6'd4, 1'b0, 9, 1'b0, 64'd64);
        runCase("rankLast", 64'hF, 6'd3, 1'b0, 3, 1'b1, 64'd3);
        runCase("wordBigK", 64'hFFFF_FFFF_FFFF_FFFF, 6'd40, 1'b1, 5, 1'b0, 64'd32);
        runCase("onesTop", 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b0, 10, 1'b1, 64'd63);
        runCase("midChunk", 64'h0000_0000_00A0_0000, 6'd1, 1'b0, 5, 1'b1, 64'd23);

        // Flush together with Start in IDLE: request is dropped.
        bus.A     = 64'h1;
        bus.K     = 6'd0;
        bus.W64   = 1'b0;
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        bus.Flush = 1'b0;
        doneSeen  = 1'b0;
        @(negedge clk);
        checkOutput("idleFlush.ready", 64'(bus.Ready), 64'd1);
        repeat (6) begin
            @(negedge clk);
            if (bus.Done === 1'b1) doneSeen = 1'b1;
        end
        checkOutput("idleFlush.noDone", 64'(doneSeen), 64'd0);
        checkOutput("idleFlush.result", bus.SelResult, 64'd23);

        // Flush in cycle t+4 of a long operation.
        bus.A     = 64'h8000_0000_0000_0000;
        bus.K     = 6'd0;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        doneSeen  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bus.Done === 1'b1) doneSeen = 1'b1;
        end
        bus.Flush = 1'b1;
        @(posedge clk);
        #1 bus.Flush = 1'b0;
        @(negedge clk);
        if (bus.Done === 1'b1) doneSeen = 1'b1;
        checkOutput("flush.ready", 64'(bus.Ready), 64'd1);
        checkOutput("flush.busy", 64'(bus.Busy), 64'd0);
        checkOutput("flush.noDone", 64'(doneSeen), 64'd0);
        checkOutput("flush.found", 64'(bus.Found), 64'd1);
        checkOutput("flush.result", bus.SelResult, 64'd23);
        @(negedge clk);
        runCase("flushRestart", 64'h2, 6'd0, 1'b0, 3, 1'b1, 64'd1);

        // Start pulsed in cycle t+2 of a busy operation is ignored.
        bus.A     = 64'h8000_0000_0000_0000;
        bus.K     = 6'd0;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (2) @(negedge clk);
        bus.A     = 64'h1;
        bus.K     = 6'd0;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        waitDone(2, lat);
        checkOutput("busyStart.latency", 64'(lat), 64'd10);
        checkOutput("busyStart.found", 64'(bus.Found), 64'd1);
        checkOutput("busyStart.result", bus.SelResult, 64'd63);
        @(negedge clk);
        checkOutput("busyStart.ready", 64'(bus.Ready), 64'd1);

        // Reset in cycle t+3 of an operation restores reset values.
        bus.A     = 64'hFF00_0000_0000_00F0;
        bus.K     = 6'd5;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("midReset.busy", 64'(bus.Busy), 64'd0);
        checkOutput("midReset.ready", 64'(bus.Ready), 64'd1);
        checkOutput("midReset.done", 64'(bus.Done), 64'd0);
        checkOutput("midReset.found", 64'(bus.Found), 64'd0);
        checkOutput("midReset.result", bus.SelResult, 64'd0);
        doneSeen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.Done === 1'b1) doneSeen = 1'b1;
        end
        checkOutput("midReset.noDone", 64'(doneSeen), 64'd0);

        runCase("afterReset", 64'h0000_0000_0000_0100, 6'd0, 1'b0, 4, 1'b1, 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
